// File: rtl/turbo_pkg.sv
// Shared definitions for the turbo decoder packet scheduler: default sizes,
// lane index type and scheduler state encoding.
package turbo_pkg;

   localparam int DEF_NUM_TURBO = 16;
   localparam int DEF_PKT_BEATS = 25;
   localparam int DEF_BUS       = 534;
   localparam int DEF_TAG_DEPTH = 16;

   typedef logic [$clog2(DEF_NUM_TURBO)-1:0] trb_idx_t;

   typedef enum logic {
      SEL  = 1'b0,
      XFER = 1'b1
   } sched_state_t;

endpackage

// File: rtl/turbo_tag_fifo.sv
// First-word-fall-through FIFO of decoder lane indices with occupancy output;
// holds the dispatch order of completed packets.
module turbo_tag_fifo
   import turbo_pkg::*;
#(
   parameter  int W     = $bits(trb_idx_t),
   parameter  int DEPTH = DEF_TAG_DEPTH,
   localparam int AW    = $clog2(DEPTH),
   localparam int LW    = AW + 1
) (
   input  logic          clk_bus,
   input  logic          rst_n,
   input  logic          push,
   input  logic [W-1:0]  push_data,
   input  logic          pop,
   output logic [W-1:0]  rd_data,
   output logic          valid,
   output logic [LW-1:0] level
);

   logic [W-1:0]  mem [DEPTH];
   logic [AW-1:0] wr_ptr;
   logic [AW-1:0] rd_ptr;
   logic          full;
   logic          do_push;
   logic          do_pop;

   assign valid   = (level != '0);
   assign full    = (level == LW'(DEPTH));
   assign do_pop  = pop & valid;
   // A push into a full FIFO is only taken when the same cycle frees a slot.
   assign do_push = push & (~full | do_pop);
   assign rd_data = mem[rd_ptr];

   always_ff @(posedge clk_bus) begin
      if (do_push) mem[wr_ptr] <= push_data;
   end

   always_ff @(posedge clk_bus) begin
      if (!rst_n) begin
         wr_ptr <= '0;
         rd_ptr <= '0;
         level  <= '0;
      end else begin
         if (do_push) wr_ptr <= wr_ptr + AW'(1);
         if (do_pop)  rd_ptr <= rd_ptr + AW'(1);
         case ({do_push, do_pop})
            2'b10:   level <= level + LW'(1);
            2'b01:   level <= level - LW'(1);
            default: level <= level;
         endcase
      end
   end

endmodule

// File: rtl/turbo_pkt_sched.sv
// Ready-aware round-robin packet scheduler: locks each whole packet to one
// decoder lane and records the lane of every completed packet in a tag FIFO.
module turbo_pkt_sched
   import turbo_pkg::*;
#(
   parameter  int NUM_TURBO             = DEF_NUM_TURBO,
   parameter  int NUM_BUS_PER_TURBO_PKT = DEF_PKT_BEATS,
   parameter  int BUS                   = DEF_BUS,
   parameter  int TAG_DEPTH             = DEF_TAG_DEPTH,
   localparam int IW                    = $clog2(NUM_TURBO),
   localparam int LW                    = $clog2(TAG_DEPTH) + 1
) (
   input  logic                 clk_bus,
   input  logic                 rst_n,
   input  logic                 sched_en,
   input  logic [BUS-1:0]       bus_data,
   input  logic                 bus_en,
   output logic                 bus_ready,
   input  logic [NUM_TURBO-1:0] dec_ready,
   output logic [BUS-1:0]       dec_data,
   output logic [NUM_TURBO-1:0] dec_en,
   output logic [IW-1:0]        tag_id,
   output logic                 tag_valid,
   input  logic                 tag_ready,
   output logic [LW-1:0]        tag_level,
   output logic [31:0]          pkt_cnt,
   output sched_state_t         dbg_state,
   output logic [IW-1:0]        dbg_rr_ptr
);

   localparam int BW = (NUM_BUS_PER_TURBO_PKT > 1) ? $clog2(NUM_BUS_PER_TURBO_PKT) : 1;
   localparam logic [BW-1:0] LAST_BEAT = BW'(NUM_BUS_PER_TURBO_PKT - 1);

   sched_state_t         state, state_nxt;
   logic [IW-1:0]        sel, sel_nxt;
   logic [IW-1:0]        rr_ptr, rr_nxt;
   logic [BW-1:0]        beat_cnt, beat_nxt;
   logic [NUM_TURBO-1:0] eligible;
   logic                 room;
   logic                 hit;
   logic [IW-1:0]        hit_lane;
   logic                 beat_acc;
   logic                 pkt_done;

   // Returns {found, lane}: first set request at or above ptr, wrapping.
   function automatic logic [IW:0] rr_pick(input logic [NUM_TURBO-1:0] req,
                                           input logic [IW-1:0]        ptr);
      logic [IW:0]   res;
      logic [IW-1:0] idx;
      res = '0;
      for (int i = NUM_TURBO - 1; i >= 0; i--) begin
         idx = ptr + IW'(i);
         if (req[idx]) res = {1'b1, idx};
      end
      return res;
   endfunction

   // Space is reserved at packet start, so the end-of-packet push always fits.
   assign room     = (tag_level < LW'(TAG_DEPTH));
   assign eligible = dec_ready & {NUM_TURBO{sched_en & room}};
   assign {hit, hit_lane} = rr_pick(eligible, rr_ptr);

   // Host handshake: a beat transfers on a rising edge where bus_en && bus_ready;
   // bus_ready never depends on bus_en, and the tag side pops on tag_valid && tag_ready.
   assign bus_ready  = (state == XFER) & dec_ready[sel];
   assign beat_acc   = bus_ready & bus_en;
   assign pkt_done   = beat_acc & (beat_cnt == LAST_BEAT);
   assign dbg_state  = state;
   assign dbg_rr_ptr = rr_ptr;

   always_comb begin
      state_nxt = state;
      sel_nxt   = sel;
      rr_nxt    = rr_ptr;
      beat_nxt  = beat_cnt;
      case (state)
         SEL: begin
            if (hit) begin
               state_nxt = XFER;
               sel_nxt   = hit_lane;
               beat_nxt  = '0;
            end
         end
         XFER: begin
            if (beat_acc) begin
               beat_nxt = beat_cnt + BW'(1);
               if (pkt_done) begin
                  state_nxt = SEL;
                  rr_nxt    = sel + IW'(1);
                  beat_nxt  = '0;
               end
            end
         end
         default: state_nxt = SEL;
      endcase
   end

   always_ff @(posedge clk_bus) begin
      if (!rst_n) begin
         state    <= SEL;
         sel      <= '0;
         rr_ptr   <= '0;
         beat_cnt <= '0;
         pkt_cnt  <= '0;
         dec_en   <= '0;
         dec_data <= '0;
      end else begin
         state    <= state_nxt;
         sel      <= sel_nxt;
         rr_ptr   <= rr_nxt;
         beat_cnt <= beat_nxt;
         pkt_cnt  <= pkt_cnt + 32'(pkt_done);
         dec_en   <= beat_acc ? (NUM_TURBO'(1) << sel) : '0;
         if (beat_acc) dec_data <= bus_data;
      end
   end

   turbo_tag_fifo #(
      .W     (IW),
      .DEPTH (TAG_DEPTH)
   ) u_tag_fifo (
      .clk_bus   (clk_bus),
      .rst_n     (rst_n),
      .push      (pkt_done),
      .push_data (sel),
      .pop       (tag_ready),
      .rd_data   (tag_id),
      .valid     (tag_valid),
      .level     (tag_level)
   );

endmodule

// File: tb/tb_turbo_pkt_sched.sv
// Bench for turbo_pkt_sched: packet-level reference model checked every cycle,
// a lane-selection vector table, directed corner sequences and random traffic.
module tb_turbo_pkt_sched;
   import turbo_pkg::*;

   localparam int N    = 16;
   localparam int NPKT = 25;
   localparam int BUS  = 534;
   localparam int TD   = 16;

   // ---------------- clock / reset / DUT ----------------
   logic           clk_bus   = 1'b0;
   logic           rst_n     = 1'b0;
   logic           sched_en  = 1'b0;
   logic           bus_en    = 1'b0;
   logic           tag_ready = 1'b0;
   logic [BUS-1:0] bus_data  = '0;
   logic [N-1:0]   dec_ready = '0;
   logic           bus_ready;
   logic [BUS-1:0] dec_data;
   logic [N-1:0]   dec_en;
   logic [3:0]     tag_id;
   logic           tag_valid;
   logic [4:0]     tag_level;
   logic [31:0]    pkt_cnt;
   sched_state_t   dbg_state;
   logic [3:0]     dbg_rr_ptr;

   always #5 clk_bus = ~clk_bus;

   turbo_pkt_sched dut (
      .clk_bus    (clk_bus),
      .rst_n      (rst_n),
      .sched_en   (sched_en),
      .bus_data   (bus_data),
      .bus_en     (bus_en),
      .bus_ready  (bus_ready),
      .dec_ready  (dec_ready),
      .dec_data   (dec_data),
      .dec_en     (dec_en),
      .tag_id     (tag_id),
      .tag_valid  (tag_valid),
      .tag_ready  (tag_ready),
      .tag_level  (tag_level),
      .pkt_cnt    (pkt_cnt),
      .dbg_state  (dbg_state),
      .dbg_rr_ptr (dbg_rr_ptr)
   );

   // ---------------- scoreboard / reference model state ----------------
   int n_checks = 0;
   int n_fail   = 0;

   bit             m_known  = 0;
   bit             m_xfer   = 0;
   int             m_lane   = 0;
   int             m_beats  = 0;
   int             m_rr     = 0;
   logic [31:0]    m_pkt    = '0;
   logic [N-1:0]   m_dec_en = '0;
   logic [BUS-1:0] m_dec_data = '0;
   logic [3:0]     exp_q[$];

   int pulse_cnt = 0;
   bit drive_seq = 0;
   bit chk_seq   = 0;
   int beat_seq  = 0;

   task automatic chk(input string name, input int act, input int exp);
      n_checks++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s at %0t: got %0d expected %0d", name, $time, act, exp);
      end
   endtask

   task automatic chk_w(input string name, input logic [BUS-1:0] act, input logic [BUS-1:0] exp);
      n_checks++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s at %0t: got %0h expected %0h", name, $time, act, exp);
      end
   endtask

   function automatic logic [BUS-1:0] rand_bus();
      logic [BUS-1:0] v;
      v = '0;
      for (int i = 0; i < 17; i++) v = {v[BUS-33:0], 32'($urandom)};
      return v;
   endfunction

   // One clock: compare outputs against the model, advance the model with the
   // inputs that the coming edge will see, then move to the next falling edge.
   task automatic step();
      bit acc;
      int sz;
      int idx;
      #1;
      if (dec_en != '0) begin
         pulse_cnt++;
         if (chk_seq) chk_w("seq_data", dec_data, BUS'(pulse_cnt - 1));
      end
      if (m_known) begin
         chk("bus_ready", int'(bus_ready), int'(m_xfer && dec_ready[m_lane]));
         chk("dec_en", int'(dec_en), int'(m_dec_en));
         chk_w("dec_data", dec_data, m_dec_data);
         chk("tag_valid", int'(tag_valid), int'(exp_q.size() > 0));
         chk("tag_level", int'(tag_level), exp_q.size());
         if (exp_q.size() > 0) chk("tag_id", int'(tag_id), int'(exp_q[0]));
         chk("pkt_cnt", int'(pkt_cnt), int'(m_pkt));
         chk("state", int'(dbg_state), m_xfer ? int'(XFER) : int'(SEL));
         chk("rr_ptr", int'(dbg_rr_ptr), m_rr);
      end
      acc = m_xfer && dec_ready[m_lane] && bus_en;
      if (!rst_n) begin
         m_known    = 1;
         m_xfer     = 0;
         m_lane     = 0;
         m_beats    = 0;
         m_rr       = 0;
         m_pkt      = '0;
         m_dec_en   = '0;
         m_dec_data = '0;
         exp_q.delete();
      end else begin
         sz = exp_q.size();
         m_dec_en = acc ? (N'(1) << m_lane) : '0;
         if (acc) m_dec_data = bus_data;
         if (!m_xfer) begin
            if (sched_en && sz < TD) begin
               for (int i = 0; i < N; i++) begin
                  idx = (m_rr + i) % N;
                  if (dec_ready[idx]) begin
                     m_xfer  = 1;
                     m_lane  = idx;
                     m_beats = 0;
                     break;
                  end
               end
            end
         end else if (acc) begin
            m_beats++;
            beat_seq++;
         end
         if (tag_ready && sz > 0) void'(exp_q.pop_front());
         if (acc && m_beats == NPKT) begin
            exp_q.push_back(4'(m_lane));
            m_pkt  = m_pkt + 1;
            m_rr   = (m_lane + 1) % N;
            m_xfer = 0;
         end
      end
      @(posedge clk_bus);
      @(negedge clk_bus);
      if (drive_seq) bus_data = BUS'(beat_seq);
   endtask

   task automatic send_pkt(input logic [N-1:0] mask, input logic tr, output int cycles);
      int start;
      start     = int'(m_pkt);
      dec_ready = mask;
      bus_en    = 1'b1;
      sched_en  = 1'b1;
      tag_ready = tr;
      cycles    = 0;
      while (int'(m_pkt) == start && cycles < 300) begin
         step();
         cycles++;
      end
      chk("pkt_in_budget", int'(int'(m_pkt) != start), 1);
   endtask

   task automatic run_to_beat(input int beat);
      int n;
      n = 0;
      while (!(m_xfer && m_beats == beat) && n < 300) begin
         step();
         n++;
      end
      chk("beat_in_budget", int'(n < 300), 1);
   endtask

   // ---------------- vector table ----------------
   typedef struct {
      logic [N-1:0] ready;
      int           lane;
      int           rr;
      int           pkts;
   } vec_t;

   vec_t vt[8];

   initial begin
      #1_000_000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   initial begin
      int cyc;
      int lane0;
      int exp_rr;

      vt[0] = '{16'hFFFF, 0, 1, 1};
      vt[1] = '{16'hFFFF, 1, 2, 2};
      vt[2] = '{16'hFFFF, 2, 3, 3};
      vt[3] = '{16'h0010, 4, 5, 4};
      vt[4] = '{16'h0011, 0, 1, 5};
      vt[5] = '{16'h8000, 15, 0, 6};
      vt[6] = '{16'h0006, 1, 2, 7};
      vt[7] = '{16'h0005, 2, 3, 8};

      rst_n = 1'b0;
      repeat (3) step();
      rst_n = 1'b1;
      #1;
      chk("rst_bus_ready", int'(bus_ready), 0);
      chk("rst_dec_en", int'(dec_en), 0);
      chk_w("rst_dec_data", dec_data, '0);
      chk("rst_tag_valid", int'(tag_valid), 0);
      chk("rst_tag_level", int'(tag_level), 0);
      chk("rst_pkt_cnt", int'(pkt_cnt), 0);

      // Lane selection, wrap-around and streaming gap
      for (int v = 0; v < 8; v++) begin
         send_pkt(vt[v].ready, 1'b1, cyc);
         chk("vec_cycles", cyc, NPKT + 1);
         chk("vec_lane", int'(dec_en), 1 << vt[v].lane);
         chk("vec_rr", int'(dbg_rr_ptr), vt[v].rr);
         chk("vec_pkt_cnt", int'(pkt_cnt), vt[v].pkts);
         chk("vec_tag_valid", int'(tag_valid), 1);
         chk("vec_tag_id", int'(tag_id), vt[v].lane);
      end

      // Lane stall after beat 10 for 5 cycles
      dec_ready = '1;
      bus_en    = 1'b1;
      tag_ready = 1'b1;
      step();
      pulse_cnt = 0;
      beat_seq  = 0;
      bus_data  = '0;
      drive_seq = 1;
      chk_seq   = 1;
      run_to_beat(10);
      dec_ready = ~(N'(1) << m_lane);
      for (int i = 0; i < 5; i++) begin
         #1;
         chk("stall_bus_ready", int'(bus_ready), 0);
         step();
      end
      dec_ready = '1;
      cyc = int'(m_pkt);
      while (int'(m_pkt) == cyc && pulse_cnt < 100) step();
      dec_ready = '0;
      step();
      chk("stall_pulses", pulse_cnt, NPKT);
      drive_seq = 0;
      chk_seq   = 0;
      repeat (3) step();

      // Tag FIFO full
      for (int p = 0; p < TD; p++) send_pkt('1, 1'b0, cyc);
      chk("full_level", int'(tag_level), TD);
      for (int i = 0; i < 5; i++) begin
         #1;
         chk("full_bus_ready", int'(bus_ready), 0);
         chk("full_state", int'(dbg_state), int'(SEL));
         step();
      end
      tag_ready = 1'b1;
      step();
      tag_ready = 1'b0;
      run_to_beat(NPKT - 1);
      #1;
      chk("pushpop_level_before", int'(tag_level), TD - 1);
      tag_ready = 1'b1;
      step();
      tag_ready = 1'b0;
      #1;
      chk("pushpop_level_after", int'(tag_level), TD - 1);
      chk("pushpop_pkt_cnt", int'(pkt_cnt), 8 + 1 + TD + 1);
      dec_ready = '0;
      tag_ready = 1'b1;
      repeat (20) step();
      chk("drain_level", int'(tag_level), 0);

      // sched_en dropped mid-packet
      dec_ready = '1;
      sched_en  = 1'b1;
      bus_en    = 1'b1;
      run_to_beat(12);
      lane0    = m_lane;
      sched_en = 1'b0;
      cyc = int'(m_pkt);
      while (int'(m_pkt) == cyc && m_beats < 100) step();
      exp_rr = (lane0 + 1) % N;
      for (int i = 0; i < 5; i++) begin
         #1;
         chk("hold_state", int'(dbg_state), int'(SEL));
         chk("hold_bus_ready", int'(bus_ready), 0);
         chk("hold_rr", int'(dbg_rr_ptr), exp_rr);
         step();
      end
      send_pkt('1, 1'b1, cyc);
      chk("resume_lane", int'(dec_en), 1 << exp_rr);

      // Reset in the middle of a packet with a tag pending
      send_pkt('1, 1'b0, cyc);
      run_to_beat(7);
      rst_n = 1'b0;
      step();
      rst_n = 1'b1;
      #1;
      chk("mid_rst_bus_ready", int'(bus_ready), 0);
      chk("mid_rst_dec_en", int'(dec_en), 0);
      chk_w("mid_rst_dec_data", dec_data, '0);
      chk("mid_rst_tag_valid", int'(tag_valid), 0);
      chk("mid_rst_tag_level", int'(tag_level), 0);
      chk("mid_rst_pkt_cnt", int'(pkt_cnt), 0);
      chk("mid_rst_state", int'(dbg_state), int'(SEL));
      send_pkt('1, 1'b1, cyc);
      chk("post_rst_lane", int'(dec_en), 1);

      // Random traffic
      for (int c = 0; c < 4000; c++) begin
         dec_ready = ($urandom_range(0, 7) == 0) ? '0 : N'($urandom);
         bus_en    = ($urandom_range(0, 3) != 0);
         tag_ready = 1'($urandom_range(0, 1));
         sched_en  = ($urandom_range(0, 9) != 0);
         bus_data  = rand_bus();
         rst_n     = ($urandom_range(0, 999) != 0);
         step();
      end
      rst_n = 1'b1;
      step();

      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule
